// File: rtl/partial_energy_calc_folded_if.sv
// Handshake bundle for the folded local-energy calculator: start request, streamed weight chunks,
// and the energy result, each on its own valid/ready pair.
interface partial_energy_calc_folded_if #(
    parameter int BITJ             = 4,
    parameter int BITH             = 4,
    parameter int DATASPIN         = 256,
    parameter int PARALLELISM      = 16,
    parameter int SCALING_BIT      = 5,
    parameter int LOCAL_ENERGY_BIT = 16
);
    // Every channel transfers on a clock edge where valid and ready are both high; the
    // producer holds valid and its payload until that edge, and ready never waits on valid.
    logic                          start_valid_i;
    logic                          start_ready_o;
    logic [DATASPIN-1:0]           spin_vector_i;
    logic                          current_spin_i;
    logic [BITH-1:0]               hbias_i;
    logic [SCALING_BIT-1:0]        hscaling_i;
    logic                          weight_valid_i;
    logic                          weight_ready_o;
    logic [PARALLELISM*BITJ-1:0]   weight_i;
    logic                          energy_valid_o;
    logic                          energy_ready_i;
    logic [LOCAL_ENERGY_BIT-1:0]   energy_o;
    logic                          overflow_o;

    modport slave (
        input  start_valid_i, spin_vector_i, current_spin_i, hbias_i, hscaling_i,
        input  weight_valid_i, weight_i, energy_ready_i,
        output start_ready_o, weight_ready_o, energy_valid_o, energy_o, overflow_o
    );

    modport master (
        output start_valid_i, spin_vector_i, current_spin_i, hbias_i, hscaling_i,
        output weight_valid_i, weight_i, energy_ready_i,
        input  start_ready_o, weight_ready_o, energy_valid_o, energy_o, overflow_o
    );
endinterface

// File: rtl/partial_energy_calc_folded.sv
// Time-multiplexed local energy of one spin: s_cur * (sum_j s_j*J_j + h*scale), consuming the
// couplings PARALLELISM at a time into a saturating accumulator with a sticky overflow flag.
module partial_energy_calc_folded #(
    parameter int BITJ             = 4,
    parameter int BITH             = 4,
    parameter int DATASPIN         = 256,
    parameter int PARALLELISM      = 16,
    parameter int SCALING_BIT      = 5,
    parameter int LOCAL_ENERGY_BIT = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    partial_energy_calc_folded_if.slave        bus,
    output logic [1:0]                         dbg_state_o
);
    localparam int NUM_CHUNKS = DATASPIN / PARALLELISM;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int SH_W       = (SCALING_BIT > 1) ? $clog2(SCALING_BIT) : 1;
    localparam int L          = LOCAL_ENERGY_BIT;
    // Wide enough that acc + chunk sum and acc + scaled bias never wrap before clamping.
    localparam int SUM_W      = L + BITJ + BITH + SCALING_BIT + $clog2(PARALLELISM) + 1;

    localparam logic signed [SUM_W-1:0] MAX_V = {{(SUM_W-L+1){1'b0}}, {(L-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] MIN_V = {{(SUM_W-L+1){1'b1}}, {(L-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [L-1:0]             acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DATASPIN-1:0]      spin_q, spin_d;
    logic                     cur_q, cur_d;
    logic [BITH-1:0]          h_q, h_d;
    logic [SCALING_BIT-1:0]   sc_q, sc_d;
    logic [L-1:0]             energy_q, energy_d;
    logic                     ovf_q, ovf_d;

    function automatic logic [L-1:0] sat(input logic signed [SUM_W-1:0] v, output logic clamped);
        logic [L-1:0] res;
        clamped = 1'b1;
        if (v > MAX_V) begin
            res = MAX_V[L-1:0];
        end else if (v < MIN_V) begin
            res = MIN_V[L-1:0];
        end else begin
            res     = v[L-1:0];
            clamped = 1'b0;
        end
        return res;
    endfunction

    logic [DATASPIN-1:0]      spin_shift;
    logic [PARALLELISM-1:0]   chunk_spins;
    logic signed [SUM_W-1:0]  term;
    logic signed [SUM_W-1:0]  chunk_sum;
    logic signed [SUM_W-1:0]  acc_ext;
    logic [L-1:0]             acc_sat;
    logic                     acc_clamp;
    logic                     is_pow2;
    logic [SH_W-1:0]          sh;
    logic signed [SUM_W-1:0]  h_ext;
    logic signed [SUM_W-1:0]  hscaled;
    logic [L-1:0]             local_v;
    logic                     local_clamp;
    logic signed [SUM_W-1:0]  neg_ext;
    logic [L-1:0]             neg_v;
    logic                     neg_clamp;
    logic [L-1:0]             final_v;
    logic                     final_clamp;

    // Datapath: chunk sum for the current weight beat, and the bias/sign finish.
    always_comb begin
        spin_shift  = spin_q >> (cnt_q * PARALLELISM);
        chunk_spins = spin_shift[PARALLELISM-1:0];
        chunk_sum   = '0;
        term        = '0;
        for (int k = 0; k < PARALLELISM; k++) begin
            term      = {{(SUM_W-BITJ){bus.weight_i[k*BITJ+BITJ-1]}}, bus.weight_i[k*BITJ +: BITJ]};
            chunk_sum = chunk_spins[k] ? (chunk_sum + term) : (chunk_sum - term);
        end
        acc_ext = {{(SUM_W-L){acc_q[L-1]}}, acc_q};
        acc_sat = sat(acc_ext + chunk_sum, acc_clamp);

        // Only exact powers of two scale the bias; anything else passes h through unscaled.
        is_pow2 = (sc_q != '0) && ((sc_q & (sc_q - SCALING_BIT'(1))) == '0);
        sh      = '0;
        for (int b = 0; b < SCALING_BIT; b++) begin
            if (sc_q[b]) sh = SH_W'(b);
        end
        h_ext   = {{(SUM_W-BITH){h_q[BITH-1]}}, h_q};
        hscaled = is_pow2 ? (h_ext <<< sh) : h_ext;

        local_v     = sat(acc_ext + hscaled, local_clamp);
        neg_ext     = -{{(SUM_W-L){local_v[L-1]}}, local_v};
        neg_v       = sat(neg_ext, neg_clamp);
        final_v     = cur_q ? local_v : neg_v;
        final_clamp = local_clamp | (~cur_q & neg_clamp);
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        spin_d   = spin_q;
        cur_d    = cur_q;
        h_d      = h_q;
        sc_d     = sc_q;
        energy_d = energy_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start_valid_i) begin
                    spin_d  = bus.spin_vector_i;
                    cur_d   = bus.current_spin_i;
                    h_d     = bus.hbias_i;
                    sc_d    = bus.hscaling_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (bus.weight_valid_i) begin
                    acc_d = acc_sat;
                    ovf_d = ovf_q | acc_clamp;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NUM_CHUNKS - 1)) state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                energy_d = final_v;
                ovf_d    = ovf_q | final_clamp;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (bus.energy_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            spin_q   <= '0;
            cur_q    <= 1'b0;
            h_q      <= '0;
            sc_q     <= '0;
            energy_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            spin_q   <= spin_d;
            cur_q    <= cur_d;
            h_q      <= h_d;
            sc_q     <= sc_d;
            energy_q <= energy_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.start_ready_o  = (state_q == S_IDLE);
    assign bus.weight_ready_o = (state_q == S_ACCUM);
    assign bus.energy_valid_o = (state_q == S_DONE);
    assign bus.energy_o       = energy_q;
    assign bus.overflow_o     = ovf_q;
    assign dbg_state_o        = state_q;
endmodule

// File: tb/tb_partial_energy_calc_folded.sv
// Bench for partial_energy_calc_folded: two instances (16-bit and 6-bit energy) share one stimulus
// stream; results are checked against a table of worked jobs plus a reference model for random jobs.
module tb_partial_energy_calc_folded;
    localparam int DS = 8;
    localparam int P  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start_valid = 1'b0;
    logic [DS-1:0] spins = '0;
    logic          cur = 1'b0;
    logic [3:0]    h = '0;
    logic [4:0]    sc = '0;
    logic          wvalid = 1'b0;
    logic [7:0]    w = '0;
    logic          eready = 1'b0;
    logic [1:0]    st16, st6;

    partial_energy_calc_folded_if #(.BITJ(4), .BITH(4), .DATASPIN(DS), .PARALLELISM(P),
        .SCALING_BIT(5), .LOCAL_ENERGY_BIT(16)) if16 ();
    partial_energy_calc_folded_if #(.BITJ(4), .BITH(4), .DATASPIN(DS), .PARALLELISM(P),
        .SCALING_BIT(5), .LOCAL_ENERGY_BIT(6)) if6 ();

    assign if16.start_valid_i  = start_valid;
    assign if16.spin_vector_i  = spins;
    assign if16.current_spin_i = cur;
    assign if16.hbias_i        = h;
    assign if16.hscaling_i     = sc;
    assign if16.weight_valid_i = wvalid;
    assign if16.weight_i       = w;
    assign if16.energy_ready_i = eready;
    assign if6.start_valid_i   = start_valid;
    assign if6.spin_vector_i   = spins;
    assign if6.current_spin_i  = cur;
    assign if6.hbias_i         = h;
    assign if6.hscaling_i      = sc;
    assign if6.weight_valid_i  = wvalid;
    assign if6.weight_i        = w;
    assign if6.energy_ready_i  = eready;

    partial_energy_calc_folded #(.BITJ(4), .BITH(4), .DATASPIN(DS), .PARALLELISM(P),
        .SCALING_BIT(5), .LOCAL_ENERGY_BIT(16)) dut16 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if16), .dbg_state_o(st16));
    partial_energy_calc_folded #(.BITJ(4), .BITH(4), .DATASPIN(DS), .PARALLELISM(P),
        .SCALING_BIT(5), .LOCAL_ENERGY_BIT(6)) dut6 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if6), .dbg_state_o(st6));

    typedef struct {
        logic [7:0]  spins;
        logic [31:0] w;       // J[i] at bits [4i +: 4]
        logic [3:0]  h;
        logic [4:0]  sc;
        logic        cur;
        int          stall_after;
        int          stall_len;
        int          bp;
        logic [15:0] e16;
        logic        o16;
        logic [15:0] e6;
        logic        o6;
    } vec_t;

    vec_t tbl[10];
    logic [33:0] exp_q[$];   // {o6, e6, o16, e16}
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] model(input vec_t v, input int lw);
        int lo, hi, acc, cs, t, hs, loc, e, s;
        bit ov;
        lo = -(1 <<< (lw - 1));
        hi = (1 <<< (lw - 1)) - 1;
        acc = 0;
        ov = 1'b0;
        for (int c = 0; c < DS / P; c++) begin
            cs = 0;
            for (int k = 0; k < P; k++) begin
                t  = $signed(v.w[(c*P+k)*4 +: 4]);
                cs = v.spins[c*P+k] ? cs + t : cs - t;
            end
            acc = acc + cs;
            if (acc > hi) begin acc = hi; ov = 1'b1; end
            if (acc < lo) begin acc = lo; ov = 1'b1; end
        end
        s  = int'(v.sc);
        hs = $signed(v.h);
        if (s != 0 && (s & (s - 1)) == 0) hs = hs * s;
        loc = acc + hs;
        if (loc > hi) begin loc = hi; ov = 1'b1; end
        if (loc < lo) begin loc = lo; ov = 1'b1; end
        e = v.cur ? loc : -loc;
        if (e > hi) begin e = hi; ov = 1'b1; end
        return {ov, 16'(e)};
    endfunction

    task automatic do_job(input vec_t v, input string tag);
        int lat, exp_lat;
        bit seen;
        logic [33:0] ex;
        logic [15:0] held;
        exp_q.push_back({v.o6, v.e6, v.o16, v.e16});
        @(negedge clk);
        check({tag, " start_ready idle"}, 32'(if16.start_ready_o), 32'd1);
        start_valid = 1'b1; spins = v.spins; cur = v.cur; h = v.h; sc = v.sc;
        wvalid = 1'b1; w = 8'($urandom);
        @(posedge clk); lat = 1;
        @(negedge clk);
        start_valid = 1'b0; spins = 8'($urandom); cur = 1'($urandom);
        h = 4'($urandom); sc = 5'($urandom);
        for (int c = 0; c < DS / P; c++) begin
            wvalid = 1'b1; w = v.w[c*8 +: 8];
            @(posedge clk); lat++;
            @(negedge clk);
            if (c == v.stall_after) begin
                for (int s = 0; s < v.stall_len; s++) begin
                    wvalid = 1'b0; w = 8'($urandom);
                    @(posedge clk); lat++;
                    @(negedge clk);
                end
            end
        end
        wvalid = 1'b1; w = 8'($urandom);
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            if (if16.energy_valid_o) seen = 1'b1;
            else begin
                @(posedge clk); lat++;
                @(negedge clk);
            end
        end
        wvalid = 1'b0;
        check({tag, " valid seen"}, 32'(seen), 32'd1);
        exp_lat = 6 + ((v.stall_after >= 0) ? v.stall_len : 0);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        ex = exp_q.pop_front();
        check({tag, " energy16"}, 32'(if16.energy_o), 32'(ex[15:0]));
        check({tag, " ovf16"}, 32'(if16.overflow_o), 32'(ex[16]));
        check({tag, " energy6"}, 32'({{10{if6.energy_o[5]}}, if6.energy_o}), 32'(ex[32:17]));
        check({tag, " ovf6"}, 32'(if6.overflow_o), 32'(ex[33]));
        held = if16.energy_o;
        for (int b = 0; b < v.bp; b++) begin
            start_valid = 1'b1; spins = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            check({tag, " bp energy stable"}, 32'(if16.energy_o), 32'(held));
            check({tag, " bp valid held"}, 32'(if16.energy_valid_o), 32'd1);
            check({tag, " bp start_ready"}, 32'(if16.start_ready_o), 32'd0);
        end
        eready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        eready = 1'b0; start_valid = 1'b0;
        check({tag, " back to idle valid"}, 32'(if16.energy_valid_o), 32'd0);
        check({tag, " back to idle ready"}, 32'(if16.start_ready_o), 32'd1);
    endtask

    initial begin
        vec_t rv;
        logic [16:0] m;
        tbl[0] = '{8'hFF, 32'h11111111, 4'h2, 5'd4,  1'b1, -1, 0, 0, 16'h0010, 1'b0, 16'h0010, 1'b0};
        tbl[1] = '{8'hFF, 32'h11111111, 4'h2, 5'd4,  1'b0, -1, 0, 5, 16'hFFF0, 1'b0, 16'hFFF0, 1'b0};
        tbl[2] = '{8'hF0, 32'h33333333, 4'hF, 5'd1,  1'b1, -1, 0, 0, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0};
        tbl[3] = '{8'hFF, 32'h11111111, 4'h2, 5'd4,  1'b1,  1, 3, 0, 16'h0010, 1'b0, 16'h0010, 1'b0};
        tbl[4] = '{8'hFF, 32'h77777777, 4'h0, 5'd1,  1'b1, -1, 0, 0, 16'h0038, 1'b0, 16'h001F, 1'b1};
        tbl[5] = '{8'hFF, 32'h77777777, 4'h0, 5'd1,  1'b0, -1, 0, 0, 16'hFFC8, 1'b0, 16'hFFE1, 1'b1};
        tbl[6] = '{8'h00, 32'h11111111, 4'h5, 5'd3,  1'b1, -1, 0, 0, 16'hFFFD, 1'b0, 16'hFFFD, 1'b0};
        tbl[7] = '{8'hFF, 32'h00000000, 4'h8, 5'd16, 1'b0, -1, 0, 0, 16'h0080, 1'b0, 16'h001F, 1'b1};
        tbl[8] = '{8'hFF, 32'h88888888, 4'h7, 5'd0,  1'b1, -1, 0, 0, 16'hFFC7, 1'b0, 16'hFFE7, 1'b1};
        tbl[9] = '{8'h00, 32'h88888888, 4'h0, 5'd1,  1'b0, -1, 0, 0, 16'hFFC0, 1'b0, 16'hFFE1, 1'b1};

        // Clock/reset: hold reset a few cycles, then check reset values.
        repeat (3) @(posedge clk);
        #1;
        check("reset energy16", 32'(if16.energy_o), 32'd0);
        check("reset ovf16", 32'(if16.overflow_o), 32'd0);
        check("reset valid16", 32'(if16.energy_valid_o), 32'd0);
        check("reset start_ready", 32'(if16.start_ready_o), 32'd1);
        check("reset weight_ready", 32'(if16.weight_ready_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) do_job(tbl[i], $sformatf("vec%0d", i));

        // Reset during chunk 2 of a job: outputs drop immediately, next job unaffected.
        @(negedge clk);
        start_valid = 1'b1; spins = 8'hFF; cur = 1'b1; h = 4'h2; sc = 5'd4;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0; wvalid = 1'b1; w = 8'h11;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("midjob state accum", 32'(st16), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midjob rst energy16", 32'(if16.energy_o), 32'd0);
        check("midjob rst energy6", 32'(if6.energy_o), 32'd0);
        check("midjob rst ovf6", 32'(if6.overflow_o), 32'd0);
        check("midjob rst valid", 32'(if16.energy_valid_o), 32'd0);
        check("midjob rst start_ready", 32'(if16.start_ready_o), 32'd1);
        check("midjob rst weight_ready", 32'(if16.weight_ready_o), 32'd0);
        check("midjob rst state", 32'(st16), 32'd0);
        wvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_job(tbl[0], "after_reset");

        for (int r = 0; r < 6; r++) begin
            rv.spins = 8'($urandom);
            rv.w     = $urandom;
            rv.h     = 4'($urandom);
            rv.sc    = 5'($urandom_range(0, 17));
            rv.cur   = 1'($urandom);
            rv.stall_after = int'($urandom_range(0, 4)) - 1;
            rv.stall_len   = int'($urandom_range(1, 3));
            rv.bp          = int'($urandom_range(0, 2));
            m = model(rv, 16);
            rv.e16 = m[15:0]; rv.o16 = m[16];
            m = model(rv, 6);
            rv.e6 = m[15:0]; rv.o6 = m[16];
            do_job(rv, $sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
